// File: rtl/multi_cycle_control.sv
// Multi-cycle control FSM: IF/ID/EX/MEM/WB/HALT with retired-instruction count.
// Define MEM_WAIT_EN to stall IF and MEM until mem_ready is asserted.
module multi_cycle_control #(
   parameter int INST_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            opcode,
   input  logic [5:0]            func,
   input  logic                  bcond,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  ir_write,
   output logic                  i_or_d,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  reg_write,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            pc_source,
   output logic [1:0]            wb_sel,
   output logic [1:0]            reg_dst,
   output logic                  is_halted,
   output logic                  wwd_valid,
   output logic [INST_CNT_W-1:0] num_inst
);

   typedef enum logic [2:0] {
      S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
   } state_e;

   state_e                state_q, state_d;
   logic [INST_CNT_W-1:0] num_q;
   logic                  retire;
   logic                  mem_ok;

`ifdef MEM_WAIT_EN
   assign mem_ok = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_ok = 1'b1;
`endif

   logic op_r, is_rtype, is_imm, is_br, is_jmp, is_jal;
   logic is_lwd, is_swd, is_jpr, is_jrl, is_wwd, is_hlt;
   logic is_arith, is_memop, is_valid;

   assign op_r     = (opcode == 4'd15);
   assign is_rtype = op_r && (func[5:3] == 3'd0);
   assign is_imm   = (opcode == 4'd4) || (opcode == 4'd5)
                  || (opcode == 4'd6);
   assign is_br    = (opcode <= 4'd3);
   assign is_lwd   = (opcode == 4'd7);
   assign is_swd   = (opcode == 4'd8);
   assign is_jmp   = (opcode == 4'd9);
   assign is_jal   = (opcode == 4'd10);
   assign is_jpr   = op_r && (func == 6'd25);
   assign is_jrl   = op_r && (func == 6'd26);
   assign is_wwd   = op_r && (func == 6'd28);
   assign is_hlt   = op_r && (func == 6'd29);
   assign is_arith = is_rtype || is_imm;
   assign is_memop = is_lwd || is_swd;
   assign is_valid = is_arith || is_br || is_jmp || is_jal
                  || is_jpr || is_jrl || is_wwd || is_memop
                  || is_hlt;

   always_comb begin
      state_d   = state_q;
      retire    = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      pc_source = 2'd0;
      wb_sel    = 2'd0;
      reg_dst   = 2'd0;
      is_halted = 1'b0;
      wwd_valid = 1'b0;
      unique case (state_q)
         S_IF: begin
            mem_read  = 1'b1;
            ir_write  = mem_ok;
            pc_write  = mem_ok;
            alu_src_b = 2'd1;
            if (mem_ok) state_d = S_ID;
         end
         S_ID: begin
            if (is_hlt) begin
               state_d = S_HALT;
               retire  = 1'b1;
            end else if (!is_valid) begin
               state_d = S_IF;
               retire  = 1'b1;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            state_d = S_IF;
            retire  = 1'b1;
            unique case (1'b1)
               is_arith: begin
                  alu_src_a = 1'b1;
                  alu_src_b = is_rtype ? 2'd0 : 2'd2;
                  state_d   = S_WB;
                  retire    = 1'b0;
               end
               is_br: begin
                  pc_write  = bcond;
                  pc_source = 2'd1;
               end
               is_jmp: begin
                  pc_write  = 1'b1;
                  pc_source = 2'd2;
               end
               is_jal: begin
                  pc_write  = 1'b1;
                  pc_source = 2'd2;
                  reg_write = 1'b1;
                  reg_dst   = 2'd2;
                  wb_sel    = 2'd2;
               end
               is_jpr: begin
                  pc_write  = 1'b1;
                  pc_source = 2'd3;
               end
               is_jrl: begin
                  pc_write  = 1'b1;
                  pc_source = 2'd3;
                  reg_write = 1'b1;
                  reg_dst   = 2'd2;
                  wb_sel    = 2'd2;
               end
               is_wwd: wwd_valid = 1'b1;
               is_memop: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'd2;
                  state_d   = S_MEM;
                  retire    = 1'b0;
               end
               default: state_d = S_IF;
            endcase
         end
         S_MEM: begin
            i_or_d = 1'b1;
            if (is_lwd) begin
               mem_read = 1'b1;
               if (mem_ok) state_d = S_WB;
            end else begin
               mem_write = 1'b1;
               if (mem_ok) begin
                  state_d = S_IF;
                  retire  = 1'b1;
               end
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            reg_dst   = is_rtype ? 2'd1 : 2'd0;
            wb_sel    = is_lwd ? 2'd1 : 2'd0;
            state_d   = S_IF;
            retire    = 1'b1;
         end
         S_HALT: is_halted = 1'b1;
         default: state_d = S_IF;
      endcase
      // Reset cycle shows a quiet datapath regardless of current state.
      if (reset) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         i_or_d    = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
         alu_src_a = 1'b0;
         alu_src_b = 2'd0;
         pc_source = 2'd0;
         wb_sel    = 2'd0;
         reg_dst   = 2'd0;
         is_halted = 1'b0;
         wwd_valid = 1'b0;
         retire    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IF;
         num_q   <= '0;
      end else begin
         state_q <= state_d;
         if (retire)
            num_q <= num_q + {{(INST_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign num_inst = num_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control; a 4-bit counter instance checks wrap.
module tb_multi_cycle_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  opcode;
   logic [5:0]  func;
   logic        bcond;
   logic        mem_ready;
   logic        pc_write, ir_write, i_or_d, mem_read, mem_write;
   logic        reg_write, alu_src_a, is_halted, wwd_valid;
   logic [1:0]  alu_src_b, pc_source, wb_sel, reg_dst;
   logic [15:0] num_inst;
   logic [16:0] unused_w;
   logic [3:0]  num_w;
   logic [16:0] obs;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multi_cycle_control #(.INST_CNT_W(16)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .func(func),
      .bcond(bcond), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .pc_source(pc_source),
      .wb_sel(wb_sel), .reg_dst(reg_dst), .is_halted(is_halted),
      .wwd_valid(wwd_valid), .num_inst(num_inst)
   );

   multi_cycle_control #(.INST_CNT_W(4)) u_w (
      .clk(clk), .reset(reset), .opcode(opcode), .func(func),
      .bcond(bcond), .mem_ready(mem_ready),
      .pc_write(unused_w[0]), .ir_write(unused_w[1]),
      .i_or_d(unused_w[2]), .mem_read(unused_w[3]),
      .mem_write(unused_w[4]), .reg_write(unused_w[5]),
      .alu_src_a(unused_w[6]), .alu_src_b(unused_w[8:7]),
      .pc_source(unused_w[10:9]), .wb_sel(unused_w[12:11]),
      .reg_dst(unused_w[14:13]), .is_halted(unused_w[15]),
      .wwd_valid(unused_w[16]), .num_inst(num_w)
   );

   assign obs = {pc_write, ir_write, i_or_d, mem_read, mem_write,
                 reg_write, alu_src_a, alu_src_b, pc_source,
                 wb_sel, reg_dst, is_halted, wwd_valid};

   function automatic logic [16:0] mk(
      logic pcw, logic irw, logic iod, logic mr, logic mw,
      logic rw, logic asa, logic [1:0] asb, logic [1:0] pcs,
      logic [1:0] wbs, logic [1:0] rd, logic hlt, logic wwd);
      return {pcw, irw, iod, mr, mw, rw, asa, asb, pcs,
              wbs, rd, hlt, wwd};
   endfunction

   localparam logic [16:0] E_0    = 17'd0;
   localparam logic [16:0] E_IF   = mk(1,1,0,1,0,0,0,2'd1,2'd0,2'd0,2'd0,0,0);
   localparam logic [16:0] E_EXI  = mk(0,0,0,0,0,0,1,2'd2,2'd0,2'd0,2'd0,0,0);
   localparam logic [16:0] E_EXR  = mk(0,0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,0,0);
   localparam logic [16:0] E_WBI  = mk(0,0,0,0,0,1,0,2'd0,2'd0,2'd0,2'd0,0,0);
   localparam logic [16:0] E_WBR  = mk(0,0,0,0,0,1,0,2'd0,2'd0,2'd0,2'd1,0,0);
   localparam logic [16:0] E_WBL  = mk(0,0,0,0,0,1,0,2'd0,2'd0,2'd1,2'd0,0,0);
   localparam logic [16:0] E_MEML = mk(0,0,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,0,0);
   localparam logic [16:0] E_MEMS = mk(0,0,1,0,1,0,0,2'd0,2'd0,2'd0,2'd0,0,0);
   localparam logic [16:0] E_BR0  = mk(0,0,0,0,0,0,0,2'd0,2'd1,2'd0,2'd0,0,0);
   localparam logic [16:0] E_BR1  = mk(1,0,0,0,0,0,0,2'd0,2'd1,2'd0,2'd0,0,0);
   localparam logic [16:0] E_JAL  = mk(1,0,0,0,0,1,0,2'd0,2'd2,2'd2,2'd2,0,0);
   localparam logic [16:0] E_JRL  = mk(1,0,0,0,0,1,0,2'd0,2'd3,2'd2,2'd2,0,0);
   localparam logic [16:0] E_WWD  = mk(0,0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,0,1);
   localparam logic [16:0] E_HLT  = mk(0,0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,0);

   task automatic chk(string tag, logic [16:0] eo, logic [15:0] en);
      checks++;
      assert ({obs, num_inst} === {eo, en}) else begin
         errors++;
         $error("FAIL %s: observed out=%h num=%h expected out=%h num=%h",
                tag, obs, num_inst, eo, en);
      end
   endtask

   task automatic chkw(string tag, logic [3:0] en);
      checks++;
      assert (num_w === en) else begin
         errors++;
         $error("FAIL %s: observed num=%h expected num=%h",
                tag, num_w, en);
      end
   endtask

   task automatic cyc(string tag, logic [16:0] eo, logic [15:0] en);
      #1;
      chk(tag, eo, en);
      @(posedge clk);
      #1;
   endtask

   task automatic setop(logic [3:0] op, logic [5:0] fn);
      opcode = op;
      func   = fn;
   endtask

   initial begin
      reset     = 1'b1;
      opcode    = 4'd0;
      func      = 6'd0;
      bcond     = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      setop(4'd4, 6'd0);
      cyc("reset_cycle", E_0, 16'd0);
      reset = 1'b0;
      cyc("adi_if", E_IF, 16'd0);
      cyc("adi_id", E_0, 16'd0);
      cyc("adi_ex", E_EXI, 16'd0);
      cyc("adi_wb", E_WBI, 16'd0);
      setop(4'd7, 6'd0);
      cyc("lwd_if", E_IF, 16'd1);
      cyc("lwd_id", E_0, 16'd1);
      cyc("lwd_ex", E_EXI, 16'd1);
      cyc("lwd_mem", E_MEML, 16'd1);
      cyc("lwd_wb", E_WBL, 16'd1);
      setop(4'd8, 6'd0);
      cyc("swd_if", E_IF, 16'd2);
      cyc("swd_id", E_0, 16'd2);
      cyc("swd_ex", E_EXI, 16'd2);
      cyc("swd_mem", E_MEMS, 16'd2);
      setop(4'd1, 6'd0);
      cyc("beq0_if", E_IF, 16'd3);
      cyc("beq0_id", E_0, 16'd3);
      cyc("beq0_ex", E_BR0, 16'd3);
      bcond = 1'b1;
      cyc("beq1_if", E_IF, 16'd4);
      cyc("beq1_id", E_0, 16'd4);
      cyc("beq1_ex", E_BR1, 16'd4);
      bcond = 1'b0;
      setop(4'd10, 6'd0);
      cyc("jal_if", E_IF, 16'd5);
      cyc("jal_id", E_0, 16'd5);
      cyc("jal_ex", E_JAL, 16'd5);
      setop(4'd15, 6'd26);
      cyc("jrl_if", E_IF, 16'd6);
      cyc("jrl_id", E_0, 16'd6);
      cyc("jrl_ex", E_JRL, 16'd6);
      setop(4'd15, 6'd28);
      cyc("wwd_if", E_IF, 16'd7);
      cyc("wwd_id", E_0, 16'd7);
      cyc("wwd_ex", E_WWD, 16'd7);
      setop(4'd15, 6'd0);
      cyc("add_if", E_IF, 16'd8);
      cyc("add_id", E_0, 16'd8);
      cyc("add_ex", E_EXR, 16'd8);
      cyc("add_wb", E_WBR, 16'd8);
      setop(4'd11, 6'd0);
      cyc("undef_if", E_IF, 16'd9);
      cyc("undef_id", E_0, 16'd9);
      reset = 1'b1;
      cyc("reset_mid", E_0, 16'd10);
      reset = 1'b0;
      setop(4'd15, 6'd29);
      cyc("hlt_if", E_IF, 16'd0);
      cyc("hlt_id", E_0, 16'd0);
      bcond = 1'b1;
      cyc("halt_c3", E_HLT, 16'd1);
      cyc("halt_c4", E_HLT, 16'd1);
      cyc("halt_c5", E_HLT, 16'd1);
      bcond = 1'b0;
      reset = 1'b1;
      cyc("reset_halt", E_0, 16'd1);
      reset = 1'b0;
      setop(4'd12, 6'd0);
      for (int k = 0; k < 16; k++) begin
         cyc("loop_if", E_IF, 16'(k));
         chkw("wrap_cnt", 4'(k));
         cyc("loop_id", E_0, 16'(k));
      end
      chkw("wrap_zero", 4'd0);
      cyc("after_wrap_if", E_IF, 16'd16);
      cyc("after_wrap_id", E_0, 16'd16);
`ifdef MEM_WAIT_EN
      setop(4'd7, 6'd0);
      cyc("wait_if", E_IF, 16'd17);
      cyc("wait_id", E_0, 16'd17);
      cyc("wait_ex", E_EXI, 16'd17);
      mem_ready = 1'b0;
      cyc("wait_mem0", E_MEML, 16'd17);
      cyc("wait_mem1", E_MEML, 16'd17);
      cyc("wait_mem2", E_MEML, 16'd17);
      mem_ready = 1'b1;
      cyc("wait_mem3", E_MEML, 16'd17);
      cyc("wait_wb", E_WBL, 16'd17);
      cyc("wait_next_if", E_IF, 16'd18);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
